led_pattern_gen: RTL and testbench



---
 rtl/led_pkg.sv | 17 +
 rtl/led_pattern_gen_if.sv | 14 +
 rtl/led_prescaler.sv | 39 +++
 rtl/led_pattern_gen.sv | 105 ++++++++++
 tb/tb_led_pattern_gen.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings, scanner direction
// and the gray-code helper.
package led_pkg;

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_SCAN = 2'd2;
  localparam logic [1:0] MODE_ROT  = 2'd3;

  typedef enum logic {ScanUp, ScanDown} scan_dir_e;

  // Works for any width up to 32: narrower callers zero-extend and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control and LED-output bundle of the pattern engine.
interface led_pattern_gen_if #(
  parameter int unsigned N_LEDS = 8
);
  logic [1:0]        mode;
  logic              run;
  logic              step;
  logic              dir;
  logic              tick;
  logic [N_LEDS-1:0] leds;

  modport master (output mode, run, step, dir, input tick, leds);
  modport slave  (input mode, run, step, dir, output tick, leds);
endinterface

// File: rtl/led_prescaler.sv
// Programmable step prescaler; adv is a prescaler terminal count while running,
// or the raw step level while paused.
module led_prescaler #(
  parameter longint unsigned DIV   = 64'd16777216,
  parameter int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic step_i,
  input  logic clr_i,
  output logic adv_o
);

  localparam logic [CNT_W-1:0] Term = CNT_W'(DIV - 64'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_term;

  always_comb begin
    at_term = (cnt_q == Term);
    adv_o   = run_i ? at_term : step_i;
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: binary, gray, bouncing scanner or rotating one-hot, advanced
// by a prescaled tick or single steps, with a registered LED output.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned     N_LEDS = 8,
  parameter longint unsigned DIV    = 64'd16777216
) (
  input logic               clk,
  input logic               rst_n,
  led_pattern_gen_if.slave  bus
);

  localparam int unsigned     CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned     POS_W   = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] PosLast = POS_W'(N_LEDS - 1);

  logic              adv;
  logic              mode_chg;
  logic [1:0]        mode_q;
  logic [N_LEDS-1:0] value_q, value_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  scan_dir_e         scan_dir_q, scan_dir_d;
  logic              tick_q, tick_d;
  logic [N_LEDS-1:0] leds_q, leds_d;

  led_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (bus.run),
    .step_i (bus.step),
    .clr_i  (mode_chg),
    .adv_o  (adv)
  );

  always_comb begin
    mode_chg   = (bus.mode != mode_q);
    value_d    = value_q;
    pos_d      = pos_q;
    scan_dir_d = scan_dir_q;
    tick_d     = adv & ~mode_chg;

    // A mode change reinitialises state and swallows any coincident advance.
    if (mode_chg) begin
      value_d    = '0;
      pos_d      = '0;
      scan_dir_d = ScanUp;
    end else if (adv) begin
      unique case (mode_q)
        MODE_BIN, MODE_GRAY: begin
          value_d = bus.dir ? value_q - N_LEDS'(1) : value_q + N_LEDS'(1);
        end
        MODE_SCAN: begin
          if (scan_dir_q == ScanUp) begin
            pos_d = pos_q + POS_W'(1);
            if (pos_d == PosLast) scan_dir_d = ScanDown;
          end else begin
            pos_d = pos_q - POS_W'(1);
            if (pos_d == '0) scan_dir_d = ScanUp;
          end
        end
        MODE_ROT: begin
          if (bus.dir) begin
            pos_d = (pos_q == '0) ? PosLast : pos_q - POS_W'(1);
          end else begin
            pos_d = (pos_q == PosLast) ? '0 : pos_q + POS_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Pattern of the next state, so leds move on the same edge as the state.
    unique case (bus.mode)
      MODE_BIN:  leds_d = value_d;
      MODE_GRAY: leds_d = N_LEDS'(bin2gray(32'(value_d)));
      default:   leds_d = N_LEDS'(1) << pos_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_BIN;
      value_q    <= '0;
      pos_q      <= '0;
      scan_dir_q <= ScanUp;
      tick_q     <= 1'b0;
      leds_q     <= '0;
    end else begin
      mode_q     <= bus.mode;
      value_q    <= value_d;
      pos_q      <= pos_d;
      scan_dir_q <= scan_dir_d;
      tick_q     <= tick_d;
      leds_q     <= leds_d;
    end
  end

  assign bus.tick = tick_q;
  assign bus.leds = leds_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LEDS=4, DIV=4.
module tb_led_pattern_gen;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  led_pattern_gen_if #(.N_LEDS(4)) bus ();

  led_pattern_gen #(
    .N_LEDS (4),
    .DIV    (64'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_leds, input logic exp_tick);
    compared++;
    assert (bus.leds === exp_leds) else begin
      mismatched++;
      $error("FAIL %s leds: observed %b expected %b", tag, bus.leds, exp_leds);
    end
    compared++;
    assert (bus.tick === exp_tick) else begin
      mismatched++;
      $error("FAIL %s tick: observed %b expected %b", tag, bus.tick, exp_tick);
    end
  endtask

  logic [3:0] gray_exp [7];
  logic [3:0] scan_exp [7];
  logic [3:0] rot_exp  [4];

  initial begin
    compared   = 0;
    mismatched = 0;
    gray_exp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};
    scan_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    rot_exp  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    rst_n    = 1'b0;
    bus.mode = 2'd0;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    bus.dir  = 1'b0;
    #12;
    chk("reset", 4'b0000, 1'b0);
    cycles(1);
    rst_n   = 1'b1;
    bus.run = 1'b1;

    // Binary up count: one tick per 4 cycles, wrapping after 16.
    for (int i = 1; i <= 16; i++) begin
      cycles(3);
      chk("bin_gap", 4'(i - 1), 1'b0);
      cycles(1);
      chk("bin_tick", 4'(i), 1'b1);
    end

    // Gray count from a fresh mode entry.
    bus.mode = 2'd1;
    cycles(1);
    chk("gray_enter", 4'b0000, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycles(4);
      chk("gray_seq", gray_exp[i], 1'b1);
    end

    // Gray down from 0: value 1111 -> gray 1000.
    bus.mode = 2'd0;
    bus.dir  = 1'b1;
    cycles(1);
    bus.mode = 2'd1;
    cycles(1);
    chk("gray_reenter", 4'b0000, 1'b0);
    cycles(4);
    chk("gray_down", 4'b1000, 1'b1);

    // Scanner bounces regardless of dir.
    bus.mode = 2'd2;
    bus.dir  = 1'b0;
    cycles(1);
    chk("scan_enter", 4'b0001, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycles(4);
      chk("scan_seq", scan_exp[i], 1'b1);
      bus.dir = ~bus.dir;
    end

    // Rotate right.
    bus.mode = 2'd3;
    bus.dir  = 1'b1;
    cycles(1);
    chk("rot_enter", 4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycles(4);
      chk("rot_seq", rot_exp[i], 1'b1);
    end

    // Single steps while paused.
    bus.mode = 2'd0;
    bus.dir  = 1'b0;
    bus.run  = 1'b0;
    cycles(1);
    chk("step_enter", 4'b0000, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      bus.step = 1'b1;
      cycles(1);
      chk("step_tick", 4'(i), 1'b1);
      bus.step = 1'b0;
      cycles(1);
      chk("step_idle", 4'(i), 1'b0);
    end
    cycles(5);
    chk("paused_hold", 4'b0011, 1'b0);

    // Step ignored while running; prescaler at 2 reaches terminal after 2 cycles.
    bus.run = 1'b1;
    cycles(2);
    bus.step = 1'b1;
    cycles(1);
    bus.step = 1'b0;
    chk("step_ignored", 4'b0011, 1'b0);
    cycles(1);
    chk("run_tick", 4'b0100, 1'b1);

    // Pause mid-count freezes the prescaler; resume gives no extra tick.
    cycles(2);
    bus.run = 1'b0;
    cycles(5);
    chk("freeze", 4'b0100, 1'b0);
    bus.run = 1'b1;
    cycles(1);
    chk("resume_gap", 4'b0100, 1'b0);
    cycles(1);
    chk("resume_tick", 4'b0101, 1'b1);

    // Mode change coincident with an advance wins.
    cycles(3);
    bus.mode = 2'd2;
    cycles(1);
    chk("mode_vs_adv", 4'b0001, 1'b0);
    cycles(4);
    chk("scan_after_chg", 4'b0010, 1'b1);

    // Asynchronous reset clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 1'b0);
    #1;
    rst_n = 1'b1;
    cycles(1);
    chk("post_reset", 4'b0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
